// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the fetch sequencer.
// Holds the sequencer state enum and the cycle counter width.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int PC_W_DEF   = 10;
  localparam int LUT_AW_DEF = 2;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/fetch_sequencer_branch_lut.sv
// branch_lut: 2^AW x DW branch target table, one write port,
// one combinational read port, synchronous active-low clear.
module branch_lut #(
  parameter int AW = 2,
  parameter int DW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IDLE/RUN/DONE program counter sequencer with a
// branch target table. FETCH_CYCLE_COUNT_EN adds a RUN-cycle counter.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              branch,
  input  logic [LUT_AW-1:0] how_high,
  input  logic              halt_instr,
  input  logic              stall,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              fetch_valid,
  output logic              done,
  output logic              pc_wrap
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  cycle_count
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            wrap_q, wrap_d;
  logic [PC_W-1:0] tgt;

  branch_lut #(
    .AW (LUT_AW),
    .DW (PC_W)
  ) u_lut (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .we_i    (lut_we),
    .waddr_i (lut_waddr),
    .wdata_i (lut_wdata),
    .raddr_i (how_high),
    .rdata_o (tgt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          wrap_d  = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt_instr) begin
            state_d = DONE;
          end else if (branch) begin
            pc_d = tgt;
          end else begin
            pc_d = pc_q + PC_W'(1);
            if (&pc_q) wrap_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        wrap_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign pc_wrap     = wrap_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (start) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plus random stimulus for fetch_sequencer,
// checked against a behavioural model of the sequencing rules.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       branch;
  logic [1:0] how_high;
  logic       halt_instr;
  logic       stall;
  logic       lut_we;
  logic [1:0] lut_waddr;
  logic [9:0] lut_wdata;
  logic [9:0] pc;
  logic       fetch_valid;
  logic       done;
  logic       pc_wrap;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  bit m_run, m_done, m_wrap;
  int m_pc, m_cnt;
  int m_lut [4];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .branch      (branch),
    .how_high    (how_high),
    .halt_instr  (halt_instr),
    .stall       (stall),
    .lut_we      (lut_we),
    .lut_waddr   (lut_waddr),
    .lut_wdata   (lut_wdata),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .done        (done),
    .pc_wrap     (pc_wrap)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: applies the sequencing rules to the inputs seen at the edge.
  task automatic model();
    int old_tgt;
    if (!reset_n) begin
      m_run = 0; m_done = 0; m_pc = 0; m_wrap = 0; m_cnt = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      return;
    end
    old_tgt = m_lut[how_high];
    if (m_run) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!stall) begin
        if (halt_instr) begin
          m_run = 0; m_done = 1;
        end else if (branch) begin
          m_pc = old_tgt;
        end else begin
          m_pc = (m_pc + 1) % 1024;
          if (m_pc == 0) m_wrap = 1;
        end
      end
    end else if (start) begin
      m_run = 1; m_done = 0; m_pc = 0; m_wrap = 0; m_cnt = 0;
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("fetch_valid", 32'(fetch_valid), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
`endif
  endtask

  task automatic quiet();
    reset_n = 1; start = 0; branch = 0; how_high = 0;
    halt_instr = 0; stall = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  task automatic plain(input int n);
    quiet();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    quiet();
    reset_n = 0;
    step();
    step();
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_valid", 32'(fetch_valid), 32'h0);

    quiet(); lut_we = 1; lut_waddr = 2; lut_wdata = 10'h040;
    step();
    quiet(); start = 1;
    step();
    chk("start_pc", 32'(pc), 32'h0);
    chk("start_valid", 32'(fetch_valid), 32'h1);
    plain(5);
    chk("five_steps_pc", 32'(pc), 32'h5);

    quiet(); halt_instr = 1; step();
    quiet(); start = 1; step();
    plain(3);
    quiet(); branch = 1; how_high = 2;
    lut_we = 1; lut_waddr = 2; lut_wdata = 10'h050;
    step();
    chk("branch_old_tgt", 32'(pc), 32'h040);
    quiet(); branch = 1; how_high = 2; step();
    chk("branch_new_tgt", 32'(pc), 32'h050);

    quiet(); start = 1; step();
    chk("start_ignored_pc", 32'(pc), 32'h051);
    quiet(); halt_instr = 1; step();
    quiet(); start = 1; step();
    plain(7);
    quiet(); halt_instr = 1; branch = 1; how_high = 2; step();
    chk("halt_pc", 32'(pc), 32'h7);
    chk("halt_done", 32'(done), 32'h1);
    chk("halt_valid", 32'(fetch_valid), 32'h0);
    plain(2);
    chk("done_hold_pc", 32'(pc), 32'h7);
    quiet(); start = 1; step();
    chk("restart_done", 32'(done), 32'h0);

    plain(9);
    for (int i = 0; i < 3; i++) begin
      quiet(); stall = 1; branch = 1; halt_instr = 1; how_high = 2;
      step();
    end
    chk("stall_pc", 32'(pc), 32'h9);
    chk("stall_valid", 32'(fetch_valid), 32'h1);
    plain(1);
    chk("unstall_pc", 32'(pc), 32'hA);

    quiet(); lut_we = 1; lut_waddr = 1; lut_wdata = 10'h3FA; step();
    quiet(); branch = 1; how_high = 1; step();
    plain(5);
    chk("top_pc", 32'(pc), 32'h3FF);
    chk("top_nowrap", 32'(pc_wrap), 32'h0);
    plain(1);
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_flag", 32'(pc_wrap), 32'h1);
    quiet(); reset_n = 0; step();
    chk("midrun_rst_pc", 32'(pc), 32'h0);
    chk("midrun_rst_wrap", 32'(pc_wrap), 32'h0);
    chk("midrun_rst_valid", 32'(fetch_valid), 32'h0);
    quiet(); start = 1; step();
    plain(4);
    quiet(); branch = 1; how_high = 1; step();
    chk("lut_cleared", 32'(pc), 32'h0);

    for (int i = 0; i < 400; i++) begin
      reset_n    = ($urandom_range(63) != 0);
      start      = ($urandom_range(7) == 0);
      branch     = ($urandom_range(3) == 0);
      how_high   = 2'($urandom_range(3));
      halt_instr = ($urandom_range(15) == 0);
      stall      = ($urandom_range(4) == 0);
      lut_we     = ($urandom_range(3) == 0);
      lut_waddr  = 2'($urandom_range(3));
      lut_wdata  = 10'($urandom);
      step();
    end

`ifdef FETCH_CYCLE_COUNT_EN
    quiet(); reset_n = 0; step();
    quiet(); start = 1; step();
    plain(7);
    for (int i = 0; i < 2; i++) begin
      quiet(); stall = 1; step();
    end
    quiet(); halt_instr = 1; step();
    chk("count_ten", 32'(cycle_count), 32'd10);
    plain(3);
    chk("count_hold_done", 32'(cycle_count), 32'd10);
    quiet(); start = 1; step();
    chk("count_clear", 32'(cycle_count), 32'd0);
    plain(70000);
    chk("count_sat", 32'(cycle_count), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
